// File: rtl/rl_lj_force_accumulator_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rl_lj_force_accumulator_pkg : shared float constants, types and FSM codes
// Revision: 1.0
// ---------------------------------------------------------------------------
package rl_lj_force_accumulator_pkg;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam int          FP_BIAS  = 127;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

endpackage
`default_nettype wire

// File: rtl/rl_lj_force_accumulator_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rl_lj_force_accumulator_if : pair-force input stream and record/neighbor outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
interface rl_lj_force_accumulator_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 20,
  parameter int COUNT_WIDTH       = 16
) ();

  logic                         in_valid;
  logic [PARTICLE_ID_WIDTH-1:0] in_ref_id;
  logic [PARTICLE_ID_WIDTH-1:0] in_nb_id;
  logic [DATA_WIDTH-1:0]        in_force_x;
  logic [DATA_WIDTH-1:0]        in_force_y;
  logic [DATA_WIDTH-1:0]        in_force_z;
  logic                         in_done;

  logic                         acc_valid;
  logic [PARTICLE_ID_WIDTH-1:0] acc_ref_id;
  logic [DATA_WIDTH-1:0]        acc_force_x;
  logic [DATA_WIDTH-1:0]        acc_force_y;
  logic [DATA_WIDTH-1:0]        acc_force_z;
  logic [COUNT_WIDTH-1:0]       acc_count;

  logic                         nb_valid;
  logic [PARTICLE_ID_WIDTH-1:0] nb_id;
  logic [DATA_WIDTH-1:0]        nb_force_x;
  logic [DATA_WIDTH-1:0]        nb_force_y;
  logic [DATA_WIDTH-1:0]        nb_force_z;

  logic                         all_done;

  modport master (
    output in_valid, in_ref_id, in_nb_id, in_force_x, in_force_y, in_force_z, in_done,
    input  acc_valid, acc_ref_id, acc_force_x, acc_force_y, acc_force_z, acc_count,
    input  nb_valid, nb_id, nb_force_x, nb_force_y, nb_force_z, all_done
  );

  modport slave (
    input  in_valid, in_ref_id, in_nb_id, in_force_x, in_force_y, in_force_z, in_done,
    output acc_valid, acc_ref_id, acc_force_x, acc_force_y, acc_force_z, acc_count,
    output nb_valid, nb_id, nb_force_x, nb_force_y, nb_force_z, all_done
  );

endinterface
`default_nettype wire

// File: rtl/rl_lj_force_accumulator_fp32_add.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp32_add : combinational IEEE single adder, RNE, flush-to-zero, canonical NaN
// Revision: 1.0
// ---------------------------------------------------------------------------
module fp32_add
  import rl_lj_force_accumulator_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  localparam logic signed [9:0] EXP_INF = 10'(2 * FP_BIAS + 1);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) found = 1'b1;
      else if (!found)    n = n + 5'd1;
    end
    return n;
  endfunction

  fp32_t             a_w, b_w, big_w, sml_w;
  logic              a_zero_w, b_zero_w, a_inf_w, b_inf_w, a_nan_w, b_nan_w;
  logic [7:0]        diff_w;
  logic [26:0]       big_m_w, sml_m_w, sml_sh_w, norm_w;
  logic [27:0]       raw_w;
  logic [4:0]        lz_w;
  logic signed [9:0] exp_n_w, exp_r_w;
  logic              rnd_up_w;
  logic [24:0]       mant_w;
  logic [31:0]       calc_w;

  assign a_w = a_i;
  assign b_w = b_i;

  // Zero exponent covers denormals too, which are treated as signed zero.
  assign a_zero_w = (a_w.exp == 8'h00);
  assign b_zero_w = (b_w.exp == 8'h00);
  assign a_inf_w  = (a_w.exp == 8'hFF) && (a_w.man == 23'd0);
  assign b_inf_w  = (b_w.exp == 8'hFF) && (b_w.man == 23'd0);
  assign a_nan_w  = (a_w.exp == 8'hFF) && (a_w.man != 23'd0);
  assign b_nan_w  = (b_w.exp == 8'hFF) && (b_w.man != 23'd0);

  always_comb begin
    if ({b_w.exp, b_w.man} > {a_w.exp, a_w.man}) begin
      big_w = b_w;
      sml_w = a_w;
    end else begin
      big_w = a_w;
      sml_w = b_w;
    end
    diff_w  = big_w.exp - sml_w.exp;
    // Three extra low bits: guard, round, and a sticky OR of everything shifted out.
    big_m_w = {1'b1, big_w.man, 3'b000};
    sml_m_w = {1'b1, sml_w.man, 3'b000};
    if (diff_w >= 8'd27) sml_sh_w = 27'd1;
    else sml_sh_w = (sml_m_w >> diff_w) |
                    {26'd0, |(sml_m_w & ((27'd1 << diff_w) - 27'd1))};

    if (big_w.sign ^ sml_w.sign) raw_w = {1'b0, big_m_w} - {1'b0, sml_sh_w};
    else                         raw_w = {1'b0, big_m_w} + {1'b0, sml_sh_w};

    lz_w = 5'd0;
    if (raw_w[27]) begin
      norm_w  = {raw_w[27:2], raw_w[1] | raw_w[0]};
      exp_n_w = $signed({2'b00, big_w.exp}) + 10'sd1;
    end else begin
      lz_w    = lzc27(raw_w[26:0]);
      norm_w  = raw_w[26:0] << lz_w;
      exp_n_w = $signed({2'b00, big_w.exp}) - $signed({5'd0, lz_w});
    end

    rnd_up_w = norm_w[2] & (norm_w[1] | norm_w[0] | norm_w[3]);
    mant_w   = {1'b0, norm_w[26:3]} + {24'd0, rnd_up_w};
    exp_r_w  = exp_n_w + (mant_w[24] ? 10'sd1 : 10'sd0);

    if (raw_w == 28'd0)          calc_w = POS_ZERO;
    else if (exp_r_w >= EXP_INF) calc_w = {big_w.sign, 8'hFF, 23'd0};
    else if (exp_r_w <= 10'sd0)  calc_w = {big_w.sign, 31'd0};
    else calc_w = {big_w.sign, exp_r_w[7:0], (mant_w[24] ? 23'd0 : mant_w[22:0])};

    if (a_nan_w || b_nan_w)                            sum_o = QNAN;
    else if (a_inf_w && b_inf_w && (a_w.sign != b_w.sign)) sum_o = QNAN;
    else if (a_inf_w)                                  sum_o = a_i;
    else if (b_inf_w)                                  sum_o = b_i;
    else if (a_zero_w && b_zero_w)                     sum_o = {a_w.sign & b_w.sign, 31'd0};
    else if (a_zero_w)                                 sum_o = b_i;
    else if (b_zero_w)                                 sum_o = a_i;
    else                                               sum_o = calc_w;
  end

endmodule
`default_nettype wire

// File: rtl/rl_lj_force_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rl_lj_force_accumulator : per-reference force sums plus negated neighbor stream
// Revision: 1.0
// ---------------------------------------------------------------------------
module rl_lj_force_accumulator
  import rl_lj_force_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 20,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  rl_lj_force_accumulator_if.slave  bus
);

  logic [1:0]                         state_q, state_d;
  logic                               flush_q, flush_d;
  logic [PARTICLE_ID_WIDTH-1:0]       cur_id_q, cur_id_d;
  logic [2:0][DATA_WIDTH-1:0]         acc_q, acc_d, in_f_w, sum_w;
  logic [COUNT_WIDTH-1:0]             count_q, count_d;
  logic                               w_emit;
  logic [PARTICLE_ID_WIDTH-1:0]       w_rec_id;
  logic [2:0][DATA_WIDTH-1:0]         w_rec_f;
  logic [COUNT_WIDTH-1:0]             w_rec_cnt;
  logic                               w_nb_take;

  logic                               acc_valid_q, all_done_q, all_done_d;
  logic [PARTICLE_ID_WIDTH-1:0]       acc_ref_id_q;
  logic [2:0][DATA_WIDTH-1:0]         acc_f_q;
  logic [COUNT_WIDTH-1:0]             acc_count_q;
  logic                               nb_valid_q;
  logic [PARTICLE_ID_WIDTH-1:0]       nb_id_q;
  logic [2:0][DATA_WIDTH-1:0]         nb_f_q;

  assign in_f_w = {bus.in_force_z, bus.in_force_y, bus.in_force_x};

  for (genvar g = 0; g < 3; g++) begin : g_axis
    fp32_add u_add (
      .a_i   (acc_q[g]),
      .b_i   (in_f_w[g]),
      .sum_o (sum_w[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    cur_id_d   = cur_id_q;
    acc_d      = acc_q;
    count_d    = count_q;
    all_done_d = all_done_q;
    w_emit     = 1'b0;
    w_rec_id   = cur_id_q;
    w_rec_f    = acc_q;
    w_rec_cnt  = count_q;
    if (flush_q) begin
      // Second record of an ID-change + done cycle: the accumulator already holds it.
      w_emit     = 1'b1;
      flush_d    = 1'b0;
      state_d    = S_DONE;
      all_done_d = 1'b1;
    end else if (state_q != S_DONE) begin
      if (bus.in_valid) begin
        if (state_q == S_ACC && bus.in_ref_id == cur_id_q) begin
          acc_d   = sum_w;
          count_d = (count_q == {COUNT_WIDTH{1'b1}}) ? count_q : count_q + COUNT_WIDTH'(1);
        end else begin
          w_emit   = (state_q == S_ACC);
          acc_d    = in_f_w;
          cur_id_d = bus.in_ref_id;
          count_d  = COUNT_WIDTH'(1);
          state_d  = S_ACC;
        end
      end
      if (bus.in_done) begin
        if (w_emit) begin
          flush_d = 1'b1;
        end else begin
          if (state_d == S_ACC) begin
            w_emit    = 1'b1;
            w_rec_id  = cur_id_d;
            w_rec_f   = acc_d;
            w_rec_cnt = count_d;
          end
          state_d    = S_DONE;
          all_done_d = 1'b1;
        end
      end
    end
  end

  assign w_nb_take = bus.in_valid && (state_q != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      flush_q      <= 1'b0;
      cur_id_q     <= '0;
      acc_q        <= '0;
      count_q      <= '0;
      all_done_q   <= 1'b0;
      acc_valid_q  <= 1'b0;
      acc_ref_id_q <= '0;
      acc_f_q      <= '0;
      acc_count_q  <= '0;
      nb_valid_q   <= 1'b0;
      nb_id_q      <= '0;
      nb_f_q       <= '0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      cur_id_q    <= cur_id_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      all_done_q  <= all_done_d;
      acc_valid_q <= w_emit;
      if (w_emit) begin
        acc_ref_id_q <= w_rec_id;
        acc_f_q      <= w_rec_f;
        acc_count_q  <= w_rec_cnt;
      end
      nb_valid_q <= w_nb_take;
      if (w_nb_take) begin
        nb_id_q <= bus.in_nb_id;
        for (int i = 0; i < 3; i++)
          nb_f_q[i] <= {~in_f_w[i][DATA_WIDTH-1], in_f_w[i][DATA_WIDTH-2:0]};
      end
    end
  end

  assign bus.acc_valid   = acc_valid_q;
  assign bus.acc_ref_id  = acc_ref_id_q;
  assign bus.acc_force_x = acc_f_q[0];
  assign bus.acc_force_y = acc_f_q[1];
  assign bus.acc_force_z = acc_f_q[2];
  assign bus.acc_count   = acc_count_q;
  assign bus.nb_valid    = nb_valid_q;
  assign bus.nb_id       = nb_id_q;
  assign bus.nb_force_x  = nb_f_q[0];
  assign bus.nb_force_y  = nb_f_q[1];
  assign bus.nb_force_z  = nb_f_q[2];
  assign bus.all_done    = all_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rl_lj_force_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rl_lj_force_accumulator : directed vectors with hand-computed expectations
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_rl_lj_force_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  rl_lj_force_accumulator_if bus_if ();

  rl_lj_force_accumulator u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [19:0] rid, input logic [19:0] nid,
                       input logic [31:0] fx, input logic [31:0] fy, input logic [31:0] fz,
                       input logic done);
    bus_if.in_valid   = v;
    bus_if.in_ref_id  = rid;
    bus_if.in_nb_id   = nid;
    bus_if.in_force_x = fx;
    bus_if.in_force_y = fy;
    bus_if.in_force_z = fz;
    bus_if.in_done    = done;
  endtask

  task automatic pair(input logic [19:0] rid, input logic [31:0] fx,
                      input logic [31:0] fy, input logic [31:0] fz);
    drive(1'b1, rid, 20'h00123, fx, fy, fz, 1'b0);
    step();
  endtask

  task automatic do_reset();
    drive(1'b0, 20'd0, 20'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_rec(input string tag, input logic [19:0] id,
                         input logic [31:0] fx, input logic [15:0] cnt);
    chk({tag, ".valid"}, 64'(bus_if.acc_valid), 64'd1);
    chk({tag, ".id"},    64'(bus_if.acc_ref_id), 64'(id));
    chk({tag, ".x"},     64'(bus_if.acc_force_x), 64'(fx));
    chk({tag, ".count"}, 64'(bus_if.acc_count), 64'(cnt));
  endtask

  initial begin
    do_reset();
    chk("rst.acc_valid", 64'(bus_if.acc_valid), 64'd0);
    chk("rst.all_done",  64'(bus_if.all_done), 64'd0);
    chk("rst.nb_valid",  64'(bus_if.nb_valid), 64'd0);
    chk("rst.acc_x",     64'(bus_if.acc_force_x), 64'd0);
    chk("rst.count",     64'(bus_if.acc_count), 64'd0);

    // Three same-ID pairs then done; nb path checked on every pair.
    for (int i = 0; i < 3; i++) begin
      pair(20'd5, 32'h3F80_0000, 32'h4000_0000, 32'h0);
      chk("t1.nb_valid", 64'(bus_if.nb_valid), 64'd1);
      chk("t1.nb_id",    64'(bus_if.nb_id), 64'h00123);
      chk("t1.nb_y",     64'(bus_if.nb_force_y), 64'hC000_0000);
      chk("t1.nb_x",     64'(bus_if.nb_force_x), 64'hBF80_0000);
      chk("t1.no_rec",   64'(bus_if.acc_valid), 64'd0);
    end
    drive(1'b0, 20'd0, 20'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();
    chk_rec("t1.rec", 20'd5, 32'h4040_0000, 16'd3);
    chk("t1.all_done", 64'(bus_if.all_done), 64'd1);
    chk("t1.nb_idle",  64'(bus_if.nb_valid), 64'd0);
    drive(1'b0, 20'd0, 20'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    chk("t1.pulse_end", 64'(bus_if.acc_valid), 64'd0);
    chk("t1.done_hold", 64'(bus_if.all_done), 64'd1);

    // ID change emits the previous sum.
    do_reset();
    pair(20'd5, 32'h3F80_0000, 32'h0, 32'h0);
    pair(20'd5, 32'h4000_0000, 32'h0, 32'h0);
    chk("t2.no_rec", 64'(bus_if.acc_valid), 64'd0);
    pair(20'd7, 32'h3F00_0000, 32'h0, 32'h0);
    chk_rec("t2.rec5", 20'd5, 32'h4040_0000, 16'd2);
    chk("t2.not_done", 64'(bus_if.all_done), 64'd0);
    drive(1'b0, 20'd0, 20'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();
    chk_rec("t2.rec7", 20'd7, 32'h3F00_0000, 16'd1);
    chk("t2.all_done", 64'(bus_if.all_done), 64'd1);

    // ID change and done in one cycle: two records on consecutive cycles.
    do_reset();
    pair(20'd8, 32'h4000_0000, 32'h0, 32'h0);
    drive(1'b1, 20'd9, 20'd1, 32'h3F80_0000, 32'h0, 32'h0, 1'b1);
    step();
    chk_rec("t3.rec8", 20'd8, 32'h4000_0000, 16'd1);
    chk("t3.early_done", 64'(bus_if.all_done), 64'd0);
    drive(1'b0, 20'd0, 20'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    chk_rec("t3.rec9", 20'd9, 32'h3F80_0000, 16'd1);
    chk("t3.all_done", 64'(bus_if.all_done), 64'd1);
    drive(1'b1, 20'd9, 20'd2, 32'h3F80_0000, 32'h0, 32'h0, 1'b0);
    step();
    chk("t3.done_ign_nb",  64'(bus_if.nb_valid), 64'd0);
    chk("t3.done_ign_acc", 64'(bus_if.acc_valid), 64'd0);

    // Adder corner cases: cancellation, NaN, overflow, rounding, denormal flush.
    do_reset();
    pair(20'd20, 32'h3F80_0000, 32'h0, 32'h0);
    pair(20'd20, 32'hBF80_0000, 32'h0, 32'h0);
    pair(20'd21, 32'h3F80_0000, 32'h0, 32'h0);
    chk_rec("t4.zero", 20'd20, 32'h0000_0000, 16'd2);
    pair(20'd21, 32'h7F80_0001, 32'h0, 32'h0);
    pair(20'd22, 32'h7F7F_FFFF, 32'h0, 32'h0);
    chk_rec("t4.nan", 20'd21, 32'h7FC0_0000, 16'd2);
    pair(20'd22, 32'h7F7F_FFFF, 32'h0, 32'h0);
    pair(20'd23, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    chk_rec("t4.ovf", 20'd22, 32'h7F80_0000, 16'd2);
    pair(20'd23, 32'h3380_0000, 32'h33C0_0000, 32'h0040_0000);
    drive(1'b0, 20'd0, 20'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();
    chk_rec("t4.tie_even", 20'd23, 32'h3F80_0000, 16'd2);
    chk("t4.round_up", 64'(bus_if.acc_force_y), 64'h3F80_0001);
    chk("t4.denorm",   64'(bus_if.acc_force_z), 64'h3F80_0000);

    // Reset mid-accumulation discards the sum; done in IDLE emits nothing.
    do_reset();
    drive(1'b1, 20'd30, 20'h00055, 32'h3F80_0000, 32'h0, 32'h0, 1'b0);
    step();
    rst = 1'b1;
    drive(1'b0, 20'd0, 20'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    chk("t5.acc_valid", 64'(bus_if.acc_valid), 64'd0);
    chk("t5.nb_valid",  64'(bus_if.nb_valid), 64'd0);
    chk("t5.nb_id",     64'(bus_if.nb_id), 64'd0);
    chk("t5.nb_x",      64'(bus_if.nb_force_x), 64'd0);
    rst = 1'b0;
    drive(1'b0, 20'd0, 20'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();
    chk("t5.idle_done", 64'(bus_if.all_done), 64'd1);
    chk("t5.no_rec",    64'(bus_if.acc_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
